// File: rtl/hwpe_sel_ctrl_pkg.sv
// Shared types for the HWPE select controller: FSM state encoding and
// outstanding-counter width helper.
package hwpe_sel_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    GATED  = 2'd2,
    SETTLE = 2'd3
  } hwpe_sel_state_e;

  // Wide enough to hold 0..max_outst inclusive.
  function automatic int outst_cnt_w(input int max_outst);
    return (max_outst < 1) ? 1 : $clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/hwpe_outst_cnt.sv
// Saturating outstanding-transaction counter with a sticky overflow/underflow flag.
// idle_nxt_o reports whether the count will be zero after this cycle's update.
module hwpe_outst_cnt #(
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic idle_nxt_o,
  output logic err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             ovf, unf;

  always_comb begin
    cnt_nxt = cnt_q;
    ovf     = 1'b0;
    unf     = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) ovf = 1'b1;
      else                  cnt_nxt = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) unf = 1'b1;
      else             cnt_nxt = cnt_q - CNT_W'(1);
    end
  end

  assign idle_nxt_o = (cnt_nxt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_o <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      if (ovf || unf) err_o <= 1'b1;
    end
  end

endmodule

// File: rtl/hwpe_sel_ctrl.sv
// HWPE select/enable controller: drains the active HWPE and its buses, gates the
// clock for one cycle while swapping the selection, then lets the new clock settle.
module hwpe_sel_ctrl
  import hwpe_sel_ctrl_pkg::*;
#(
  parameter int N_HWPES       = 2,
  parameter int SEL_W         = (N_HWPES > 1) ? $clog2(N_HWPES) : 1,
  parameter int MAX_OUTST     = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sw_req_valid_i,
  output logic             sw_req_ready_o,
  input  logic [SEL_W-1:0] sw_req_sel_i,
  input  logic             sw_req_en_i,
  output logic             switch_done_o,
  input  logic             hwpe_busy_i,
  input  logic             cfg_req_i,
  input  logic             cfg_gnt_i,
  input  logic             cfg_r_valid_i,
  input  logic             tcdm_req_i,
  input  logic             tcdm_gnt_i,
  input  logic             tcdm_r_valid_i,
  output logic             cfg_stall_o,
  output logic [SEL_W-1:0] hwpe_sel_o,
  output logic             hwpe_en_o,
  output logic             err_o
);

  localparam int CNT_W = outst_cnt_w(MAX_OUTST);
  localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);

  hwpe_sel_state_e  state_q;
  logic [SEL_W-1:0] sel_q, req_sel_q;
  logic             en_q, req_en_q, done_q;
  logic [ST_W-1:0]  settle_q;

  logic cfg_inc, tcdm_inc, cfg_idle_nxt, tcdm_idle_nxt, cfg_err, tcdm_err, drained;

  assign cfg_inc  = cfg_req_i & cfg_gnt_i;
  assign tcdm_inc = tcdm_req_i & tcdm_gnt_i;

  hwpe_outst_cnt #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) u_cfg_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(cfg_inc), .dec_i(cfg_r_valid_i),
    .idle_nxt_o(cfg_idle_nxt), .err_o(cfg_err)
  );

  hwpe_outst_cnt #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) u_tcdm_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(tcdm_inc), .dec_i(tcdm_r_valid_i),
    .idle_nxt_o(tcdm_idle_nxt), .err_o(tcdm_err)
  );

  // Safe to gate once the last response retires this cycle and nothing new was granted.
  assign drained = (!hwpe_busy_i || !en_q) && cfg_idle_nxt && tcdm_idle_nxt &&
                   !cfg_inc && !tcdm_inc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      sel_q     <= '0;
      en_q      <= 1'b0;
      req_sel_q <= '0;
      req_en_q  <= 1'b0;
      settle_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (sw_req_valid_i) begin
            req_sel_q <= sw_req_sel_i;
            req_en_q  <= sw_req_en_i;
            if (sw_req_sel_i == sel_q && sw_req_en_i == en_q) done_q  <= 1'b1;
            else                                               state_q <= DRAIN;
          end
        end
        DRAIN: if (drained) state_q <= GATED;
        GATED: begin
          sel_q    <= req_sel_q;
          en_q     <= req_en_q;
          settle_q <= '0;
          if (req_en_q) begin
            state_q <= SETTLE;
          end else begin
            state_q <= RUN;
            done_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_q == ST_W'(SETTLE_CYCLES - 1)) begin
            state_q <= RUN;
            done_q  <= 1'b1;
          end else begin
            settle_q <= settle_q + ST_W'(1);
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    hwpe_en_o = en_q;
    case (state_q)
      GATED:   hwpe_en_o = 1'b0;
      SETTLE:  hwpe_en_o = 1'b1;
      default: hwpe_en_o = en_q;
    endcase
  end

  assign sw_req_ready_o = (state_q == RUN);
  assign cfg_stall_o    = (state_q != RUN);
  assign hwpe_sel_o     = sel_q;
  assign switch_done_o  = done_q;
  assign err_o          = cfg_err | tcdm_err;

endmodule

// File: tb/tb_hwpe_sel_ctrl.sv
// Directed bench for hwpe_sel_ctrl: requests push expected done events into a
// scoreboard, a negedge monitor pops and checks them; inline checks cover gating.
module tb_hwpe_sel_ctrl;
  localparam int SEL_W = 1;

  logic clk = 1'b0, rst = 1'b1;
  logic sw_req_valid = 1'b0, sw_req_ready, sw_req_en = 1'b0, switch_done;
  logic [SEL_W-1:0] sw_req_sel = '0, hwpe_sel;
  logic hwpe_busy = 1'b0, cfg_req = 1'b0, cfg_gnt = 1'b0, cfg_r_valid = 1'b0;
  logic tcdm_req = 1'b0, tcdm_gnt = 1'b0, tcdm_r_valid = 1'b0;
  logic cfg_stall, hwpe_en, err;

  int n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct {
    int               cyc;
    logic [SEL_W-1:0] sel;
    logic             en;
  } exp_t;
  exp_t sb[$];

  hwpe_sel_ctrl #(.N_HWPES(2), .SEL_W(SEL_W), .MAX_OUTST(8), .SETTLE_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .sw_req_valid_i(sw_req_valid), .sw_req_ready_o(sw_req_ready),
    .sw_req_sel_i(sw_req_sel), .sw_req_en_i(sw_req_en),
    .switch_done_o(switch_done), .hwpe_busy_i(hwpe_busy),
    .cfg_req_i(cfg_req), .cfg_gnt_i(cfg_gnt), .cfg_r_valid_i(cfg_r_valid),
    .tcdm_req_i(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_r_valid_i(tcdm_r_valid),
    .cfg_stall_o(cfg_stall), .hwpe_sel_o(hwpe_sel), .hwpe_en_o(hwpe_en), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, sw_req_ready, 1);
    chk({tag, "_done"},  switch_done,  0);
    chk({tag, "_stall"}, cfg_stall,    0);
    chk({tag, "_sel"},   hwpe_sel,     0);
    chk({tag, "_en"},    hwpe_en,      0);
    chk({tag, "_err"},   err,          0);
  endtask

  // Issues a request; lat is cycles from acceptance to the done pulse.
  // Returns at the negedge following the acceptance edge (first DRAIN cycle).
  task automatic req(input logic [SEL_W-1:0] sel, input logic en, input int lat);
    @(negedge clk);
    sw_req_valid = 1'b1;
    sw_req_sel   = sel;
    sw_req_en    = en;
    sb.push_back('{cyc + lat, sel, en});
    @(negedge clk);
    sw_req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && switch_done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_sel", hwpe_sel, e.sel);
        chk("done_en", hwpe_en, e.en);
        chk("done_stall", cfg_stall, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, queue depth %0d expected 0", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b0;

    // Switch to HWPE1 enabled from idle: 5-cycle latency, one gated cycle.
    req(1, 1, 5);
    chk("t1_drain_stall", cfg_stall, 1);
    chk("t1_drain_ready", sw_req_ready, 0);
    @(negedge clk);
    chk("t1_gated_en", hwpe_en, 0);
    chk("t1_gated_sel", hwpe_sel, 0);
    @(negedge clk);
    chk("t1_settle_en", hwpe_en, 1);
    chk("t1_settle_sel", hwpe_sel, 1);
    chk("t1_settle_stall", cfg_stall, 1);
    repeat (2) @(negedge clk);
    chk("t1_run_ready", sw_req_ready, 1);

    // Same selection: done the next cycle, no stall, no gating.
    req(1, 1, 1);
    chk("t2_stall", cfg_stall, 0);
    chk("t2_en", hwpe_en, 1);

    // Three outstanding cfg transactions hold DRAIN until the third response.
    @(negedge clk);
    cfg_req = 1'b1; cfg_gnt = 1'b1;
    repeat (3) @(negedge clk);
    cfg_req = 1'b0; cfg_gnt = 1'b0;
    req(0, 1, 9);
    @(negedge clk);
    @(negedge clk);
    cfg_r_valid = 1'b1;
    chk("t3_drain_en", hwpe_en, 1);
    chk("t3_drain_stall", cfg_stall, 1);
    repeat (2) @(negedge clk);
    chk("t3_still_drain_en", hwpe_en, 1);
    @(negedge clk);
    cfg_r_valid = 1'b0;
    chk("t3_gated_en", hwpe_en, 0);
    chk("t3_gated_sel", hwpe_sel, 1);
    @(negedge clk);
    chk("t3_settle_sel", hwpe_sel, 0);
    repeat (2) @(negedge clk);

    // Busy HWPE keeps the clock running in DRAIN for 20 cycles, then disable HWPE1.
    hwpe_busy = 1'b1;
    req(1, 0, 22);
    for (int i = 0; i < 20; i++) begin
      chk("t4_busy_en", hwpe_en, 1);
      chk("t4_busy_stall", cfg_stall, 1);
      if (i == 19) hwpe_busy = 1'b0;
      else @(negedge clk);
    end
    @(negedge clk);
    chk("t4_gated_en", hwpe_en, 0);
    chk("t4_gated_stall", cfg_stall, 1);
    @(negedge clk);

    // Disabled-to-disabled sel change: 3-cycle latency.
    req(0, 0, 3);
    chk("t5_drain_en", hwpe_en, 0);
    repeat (2) @(negedge clk);

    // tcdm overflow: err only on the grant that would exceed MAX_OUTST.
    @(negedge clk);
    tcdm_req = 1'b1; tcdm_gnt = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_err_at_max", err, 0);
    chk("t6_cnt_at_max", dut.u_tcdm_cnt.cnt_q, 8);
    @(negedge clk);
    tcdm_req = 1'b0; tcdm_gnt = 1'b0;
    chk("t6_err_ovf", err, 1);
    chk("t6_cnt_sat", dut.u_tcdm_cnt.cnt_q, 8);
    repeat (2) @(negedge clk);
    chk("t6_err_sticky", err, 1);

    rst = 1'b1;
    #1 chk_reset_vals("rst1");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;

    // cfg underflow.
    @(negedge clk);
    cfg_r_valid = 1'b1;
    @(negedge clk);
    cfg_r_valid = 1'b0;
    chk("t7_err_unf", err, 1);
    chk("t7_cnt_zero", dut.u_cfg_cnt.cnt_q, 0);
    repeat (3) @(negedge clk);
    chk("t7_err_sticky", err, 1);

    rst = 1'b1;
    #1 chk("t7_err_rst", err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted during SETTLE, then a fresh request after release.
    req(1, 1, 5);
    repeat (2) @(negedge clk);
    chk("t8_settle_en", hwpe_en, 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst2");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    req(1, 0, 3);
    chk("t8_accepted", cfg_stall, 1);
    repeat (2) @(negedge clk);
    chk("t8_sel", hwpe_sel, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hwpe_sel_ctrl.md
# hwpe_sel_ctrl

Controller for the cluster HWPE subsystem. It owns the HWPE select and enable signals that drive the per-HWPE clock gates, the config-bus steering and the TCDM static mux. Software switch requests are applied only after the active HWPE is idle and all of its config and TCDM transactions have retired. It then gates the clock, swaps the selection and lets the new clock settle before releasing the config bus.

## Interface
Parameters:
- N_HWPES, 2, number of HWPEs behind the mux
- SEL_W, max(1,$clog2(N_HWPES)), select width
- MAX_OUTST, 8, maximum outstanding transactions tracked per bus
- SETTLE_CYCLES, 2, enabled-clock cycles before config traffic is released (≥1)

Ports:
- clk_i  in  1  clock; the block is on the ungated cluster clock
- rst_i  in  1  asynchronous, active-high reset
- sw_req_valid_i  in  1  switch request valid
- sw_req_ready_o  out  1  switch request accepted
- sw_req_sel_i  in  SEL_W  target HWPE index
- sw_req_en_i  in  1  target enable
- switch_done_o  out  1  one-cycle pulse when a request has completed
- hwpe_busy_i  in  1  busy of the currently selected HWPE
- cfg_req_i, cfg_gnt_i, cfg_r_valid_i  in  1 each  config-bus monitor, taken after the stall mask
- tcdm_req_i, tcdm_gnt_i, tcdm_r_valid_i  in  1 each  HWPE TCDM port monitor
- cfg_stall_o  out  1  forces the upstream config req and gnt to 0
- hwpe_sel_o  out  SEL_W  drives hwpe_sel
- hwpe_en_o  out  1  drives hwpe_en (clock-gate enable)
- err_o  out  1  sticky counter overflow or underflow flag

## Operation
- States: RUN, DRAIN, GATED, SETTLE. Reset state is RUN, with sel_q=0 and en_q=0.
- Outstanding counters, one per bus:
  - +1 on req&gnt, −1 on r_valid; both in the same cycle leaves the count unchanged.
  - Width is $clog2(MAX_OUTST+1).
  - An increment at MAX_OUTST saturates and sets err_o.
  - A decrement at 0 stays at 0 and sets err_o.
  - err_o clears only on reset.
- RUN:
  - sw_req_ready_o=1, hwpe_en_o=en_q, cfg_stall_o=0.
  - On an accepted request, latch req_sel and req_en.
  - If req_sel==sel_q and req_en==en_q, pulse switch_done_o next cycle and stay in RUN.
  - Otherwise go to DRAIN.
- DRAIN:
  - cfg_stall_o=1, hwpe_en_o=en_q, sw_req_ready_o=0.
  - Exit to GATED when all of the following hold in the same cycle: (hwpe_busy_i==0 or en_q==0), cfg_outst==0, tcdm_outst==0, and no cfg or tcdm req&gnt.
- GATED:
  - Lasts exactly 1 cycle with hwpe_en_o=0 and cfg_stall_o=1.
  - sel_q<=req_sel and en_q<=req_en.
  - Next state is SETTLE if req_en=1; otherwise RUN, with a done pulse.
- SETTLE:
  - hwpe_en_o=1, cfg_stall_o=1, hwpe_sel_o already holds the new value.
  - Count SETTLE_CYCLES cycles, then go to RUN and pulse switch_done_o on the RUN-entry cycle.
- hwpe_sel_o=sel_q always; it changes only at the GATED→next transition.
- DRAIN has no timeout. A stuck HWPE holds the block in DRAIN and is observable through sw_req_ready_o=0.

## Timing
- Every output is a register or a decode of state only; there are no combinational paths from inputs to outputs except sw_req_ready_o, which is (state==RUN).
- Reset values: sw_req_ready_o=1, switch_done_o=0, cfg_stall_o=0, hwpe_sel_o=0, hwpe_en_o=0, err_o=0.
- Minimum latency from an accepted change request to switch_done_o, with an idle HWPE and empty counters:
  - en=1: 1 (DRAIN) + 1 (GATED) + SETTLE_CYCLES + 1 cycles.
  - en=0: 3 cycles.
- cfg_stall_o rises the cycle after acceptance. A cfg transaction granted in the acceptance cycle is counted and drained.
- Reset asserted mid-switch returns to RUN with sel 0, clock gated and counters cleared. In-flight bus responses are discarded by the system reset.

## Structure
- Package hwpe_sel_ctrl_pkg holds the state enum hwpe_sel_state_e and the counter-width localparam function.
- Sub-module hwpe_outst_cnt (saturating up/down counter with err output) is instantiated twice, once for cfg and once for tcdm.
- The FSM and the settle counter live in the top module.

## Test plan
- Reset, then sw_req sel=1 en=1 with idle inputs -> hwpe_en_o reads 0 for 1 cycle; hwpe_sel_o=1 from the SETTLE entry; switch_done_o pulses 5 cycles after acceptance with SETTLE_CYCLES=2.
- 3 cfg req&gnt with no responses, then a switch request -> the block stays in DRAIN until the 3rd cfg_r_valid_i; GATED follows on the next cycle.
- hwpe_busy_i=1 for 20 cycles during DRAIN -> hwpe_en_o stays 1 and cfg_stall_o stays 1; GATED is entered the cycle after busy falls.
- Request equal to the current sel/en -> switch_done_o pulses 1 cycle later with no stall and no clock gating.
- cfg_r_valid_i with cfg_outst==0 -> err_o=1 and remains 1; MAX_OUTST+1 grants without responses -> err_o=1 and the count saturates at MAX_OUTST.
- rst_i asserted during SETTLE -> all outputs take their reset values asynchronously; a new request is accepted after reset is released.
